// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input in core clock cycles.
// Result latency: SYNC_STAGES+1 edges from input rise to valid; no backpressure (valid is a strobe).
module pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock_12mhz,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             signal_present,
    output logic             overflow,
    output logic             level
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic               r_s_d;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_high_acc;
    logic [CNT_W-1:0]   r_period;
    logic [CNT_W-1:0]   r_high_time;
    logic               r_valid;
    logic               r_present;
    logic               r_overflow;

    logic               w_s;
    logic               w_rise;
    logic               w_fall;
    logic               w_cnt_max;
    logic               w_measure;
    logic               w_timeout;
    logic               w_latch_high;

    assign w_s       = r_sync[SYNC_STAGES-1];
    assign w_rise    = w_s & ~r_s_d;
    assign w_fall    = ~w_s & r_s_d;
    assign w_cnt_max = (r_cnt == {CNT_W{1'b1}});

    always_ff @(posedge clock_12mhz or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
            r_s_d  <= w_s;
        end
    end

    always_ff @(posedge clock_12mhz or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A qualifying edge on the saturating cycle wins over the timeout.
    always_comb begin
        w_next       = r_state;
        w_measure    = 1'b0;
        w_timeout    = 1'b0;
        w_latch_high = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_next = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (w_fall) begin
                    w_latch_high = 1'b1;
                    w_next       = ST_LOW;
                end else if (w_cnt_max && !w_rise) begin
                    w_timeout = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (w_rise) begin
                    w_measure = 1'b1;
                    w_next    = ST_HIGH;
                end else if (w_cnt_max) begin
                    w_timeout = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_12mhz or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_high_acc <= '0;
        end else begin
            if (w_rise) begin
                r_cnt <= CNT_ONE;
            end else if (r_state != ST_IDLE) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
            if (w_latch_high) begin
                r_high_acc <= r_cnt;
            end
        end
    end

    always_ff @(posedge clock_12mhz or negedge reset) begin
        if (!reset) begin
            r_period    <= '0;
            r_high_time <= '0;
            r_valid     <= 1'b0;
            r_present   <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_valid <= w_measure;
            if (w_measure) begin
                r_period    <= r_cnt;
                r_high_time <= r_high_acc;
                r_present   <= 1'b1;
                r_overflow  <= 1'b0;
            end else if (w_timeout) begin
                r_present  <= 1'b0;
                r_overflow <= 1'b1;
            end
        end
    end

    assign period         = r_period;
    assign high_time      = r_high_time;
    assign valid          = r_valid;
    assign signal_present = r_present;
    assign overflow       = r_overflow;
    assign level          = w_s;

endmodule
